// File: rtl/fetch_seq_ctrl.sv
// Instruction-fetch sequencer: one outstanding fetch at a time, redirect
// arbitration, stale-response dropping and a sticky response-timeout flag.
module fetch_seq_ctrl #(
    parameter int XLEN    = 64,
    parameter int ILEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            clint_pc_valid_i,
    input  logic [XLEN-1:0] clint_pc_i,
    input  logic            branch_pc_valid_i,
    input  logic [XLEN-1:0] branch_pc_i,
    input  logic            bpu_pc_valid_i,
    input  logic [XLEN-1:0] bpu_pc_i,
    input  logic            pipe_stall_i,
    output logic            if_req_o,
    output logic [XLEN-1:0] if_addr_o,
    input  logic            if_ack_i,
    input  logic            if_rvalid_i,
    input  logic [ILEN-1:0] if_rdata_i,
    output logic            inst_valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            pc_stall_o,
    output logic            redirect_valid_o,
    output logic [XLEN-1:0] redirect_pc_o,
    output logic            fetch_err_o
);
    localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WDOG_MAX = WDW'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_OUT  = 2'd3
    } state_e;

    state_e          state_r;
    state_e          state_nxt_s;
    logic            pend_valid_r;
    logic [XLEN-1:0] pend_pc_r;
    logic            drop_r;
    logic [WDW-1:0]  wdog_r;
    logic            fetch_err_r;
    logic [XLEN-1:0] inst_pc_r;
    logic [ILEN-1:0] inst_r;

    logic            capture_s;
    logic [XLEN-1:0] capture_pc_s;
    logic            req_s;
    logic            redirect_s;
    logic            inst_valid_s;
    logic            handoff_s;
    logic            accept_s;
    logic            rsp_s;
    logic            keep_rsp_s;

    // Redirect source arbitration: trap beats branch beats predictor
    always_comb begin
        capture_s    = 1'b1;
        capture_pc_s = clint_pc_i;
        if (clint_pc_valid_i) begin
            capture_pc_s = clint_pc_i;
        end else if (branch_pc_valid_i) begin
            capture_pc_s = branch_pc_i;
        end else if (bpu_pc_valid_i) begin
            capture_pc_s = bpu_pc_i;
        end else begin
            capture_s    = 1'b0;
            capture_pc_s = pend_pc_r;
        end
    end

    // Per-state control decode shared by next-state, datapath and outputs
    always_comb begin
        req_s        = 1'b0;
        redirect_s   = 1'b0;
        inst_valid_s = 1'b0;
        case (state_r)
            ST_REQ: begin
                req_s      = ~pend_valid_r;
                redirect_s = pend_valid_r;
            end
            ST_OUT: begin
                inst_valid_s = ~pend_valid_r;
                redirect_s   = pend_valid_r;
            end
            default: begin
                req_s = 1'b0;
            end
        endcase
        handoff_s  = inst_valid_s & ~pipe_stall_i;
        accept_s   = req_s & if_ack_i;
        rsp_s      = (state_r == ST_WAIT) & if_rvalid_i;
        // A redirect seen since the request was issued makes the response stale
        keep_rsp_s = rsp_s & ~drop_r & ~pend_valid_r;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = ST_REQ;
            ST_REQ: begin
                if (accept_s) begin
                    state_nxt_s = ST_WAIT;
                end else begin
                    state_nxt_s = ST_REQ;
                end
            end
            ST_WAIT: begin
                if (keep_rsp_s) begin
                    state_nxt_s = ST_OUT;
                end else if (rsp_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_OUT: begin
                if (redirect_s | handoff_s) begin
                    state_nxt_s = ST_REQ;
                end else begin
                    state_nxt_s = ST_OUT;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Pending redirect, stale-drop flag, watchdog and fetched-instruction latches
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_valid_r <= 1'b0;
            pend_pc_r    <= '0;
            drop_r       <= 1'b0;
            wdog_r       <= '0;
            fetch_err_r  <= 1'b0;
            inst_pc_r    <= '0;
            inst_r       <= '0;
        end else begin
            if (capture_s) begin
                pend_valid_r <= 1'b1;
                pend_pc_r    <= capture_pc_s;
            end else if (redirect_s) begin
                pend_valid_r <= 1'b0;
            end
            if (state_r == ST_WAIT) begin
                drop_r <= ~rsp_s & (drop_r | capture_s);
            end else begin
                drop_r <= 1'b0;
            end
            if ((state_r == ST_WAIT) && (state_nxt_s == ST_WAIT)) begin
                wdog_r <= (wdog_r == WDOG_MAX) ? wdog_r : wdog_r + WDW'(1);
            end else begin
                wdog_r <= '0;
            end
            if ((state_r == ST_WAIT) && (wdog_r == WDOG_MAX)) begin
                fetch_err_r <= 1'b1;
            end
            if (accept_s) begin
                inst_pc_r <= pc_i;
            end
            if (keep_rsp_s) begin
                inst_r <= if_rdata_i;
            end
        end
    end

    // Output decode; everything is forced quiet while reset is asserted
    always_comb begin
        if_req_o         = 1'b0;
        if_addr_o        = '0;
        inst_valid_o     = 1'b0;
        inst_o           = '0;
        inst_pc_o        = '0;
        pc_stall_o       = 1'b1;
        redirect_valid_o = 1'b0;
        redirect_pc_o    = '0;
        fetch_err_o      = 1'b0;
        if (rst) begin
            pc_stall_o = 1'b1;
        end else begin
            if_req_o         = req_s;
            if_addr_o        = (state_r == ST_REQ) ? pc_i : '0;
            inst_valid_o     = inst_valid_s;
            inst_o           = inst_r;
            inst_pc_o        = inst_pc_r;
            pc_stall_o       = ~(handoff_s | redirect_s);
            redirect_valid_o = redirect_s;
            redirect_pc_o    = pend_pc_r;
            fetch_err_o      = fetch_err_r;
        end
    end

endmodule
